// File: rtl/router_pkg.sv
// Shared definitions for the router-to-AXI-Stream egress path.
// Latency: n/a (types, constants and field-offset helpers only).
// Backpressure: n/a.
//
// Flit layout: {sop, eop, data[DATA_W-1:0], keep[DATA_W/8-1:0]}, keep at bit 0.
package router_pkg;

  // Framer state: between packets, or inside a packet after its sop flit.
  typedef enum logic {
    IDLE = 1'b0,
    PKT  = 1'b1
  } frm_state_t;

  function automatic int KEEP_LSB(input int data_w);
    // Keep always sits at bit 0; the argument keeps all offset helpers uniform.
    return 0 * data_w;
  endfunction

  function automatic int DATA_LSB(input int data_w);
    return data_w / 8;
  endfunction

  function automatic int EOP_BIT(input int data_w);
    return data_w + data_w / 8;
  endfunction

  function automatic int SOP_BIT(input int data_w);
    return data_w + data_w / 8 + 1;
  endfunction

endpackage

// File: rtl/r2l_fifo.sv
// Generic synchronous first-word-fall-through FIFO.
// Latency: a write is visible on rd_data the cycle after wr_en; no write-through/bypass.
// Backpressure: writes ignored when full, reads ignored when empty.
//
// Ports: clk, rst (async active-low), wr_en/wr_data (push), rd_en (pop),
//        rd_data (head entry, valid while !empty), full, empty.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module r2l_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;

  // Storage needs no reset: empty masks stale contents.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr[AW-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_rd) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_data = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/router2axis_egress.sv
// Router local-port flits -> framing check -> FWFT FIFO -> AXI4-Stream master.
// Latency: accepted flit appears on tdata 1 cycle later when the FIFO is empty.
// Backpressure: full tready support; ack drops while the FIFO is full (no write-through).
//
// Ports: clk; rst (async active-low); data_router/val/ack (router side, flit
//        {sop,eop,data,keep}); tdata/tkeep/tvalid/tready/tlast (AXIS master);
//        pkt_cnt/err_cnt (saturating statistics).
// Optional macro ROUTER2AXIS_STATS_EN enables the counters; otherwise they read 0.
module router2axis_egress
  import router_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int KEEP_W = DATA_W / 8,
  parameter int FLIT_W = DATA_W + KEEP_W + 2,
  parameter int DEPTH  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [FLIT_W-1:0] data_router,
  input  logic              val,
  output logic              ack,
  output logic [DATA_W-1:0] tdata,
  output logic [KEEP_W-1:0] tkeep,
  output logic              tvalid,
  input  logic              tready,
  output logic              tlast,
  output logic [31:0]       pkt_cnt,
  output logic [15:0]       err_cnt
);

  localparam int SOP_B  = SOP_BIT(DATA_W);
  localparam int EOP_B  = EOP_BIT(DATA_W);
  localparam int DATA_B = DATA_LSB(DATA_W);
  localparam int KEEP_B = KEEP_LSB(DATA_W);
  localparam int ENT_W  = DATA_W + KEEP_W + 1;

  frm_state_t        state;
  frm_state_t        state_nxt;
  logic              rst_ok;
  logic              acc;
  logic              wr_en;
  logic              frame_err;
  logic              keep_err;
  logic              err_any;
  logic              pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [ENT_W-1:0]  rd_ent;

  logic              f_sop;
  logic              f_eop;
  logic [DATA_W-1:0] f_data;
  logic [KEEP_W-1:0] f_keep;

  assign f_sop  = data_router[SOP_B];
  assign f_eop  = data_router[EOP_B];
  assign f_data = data_router[DATA_B +: DATA_W];
  assign f_keep = data_router[KEEP_B +: KEEP_W];

  // rst_ok goes high on the first edge after reset release, so ack is a
  // function of flops only and clears asynchronously with reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rst_ok <= 1'b0;
      state  <= IDLE;
    end else begin
      rst_ok <= 1'b1;
      state  <= state_nxt;
    end
  end

  assign ack = rst_ok && !fifo_full;
  assign acc = val && ack;

  always_comb begin
    state_nxt = state;
    wr_en     = 1'b0;
    frame_err = 1'b0;
    if (acc) begin
      case (state)
        IDLE: begin
          if (f_sop) begin
            wr_en = 1'b1;
            if (!f_eop) state_nxt = PKT;
          end else begin
            // Orphan continuation: drop it.
            frame_err = 1'b1;
          end
        end
        PKT: begin
          // A stray sop mid-packet is carried as an ordinary continuation.
          wr_en = 1'b1;
          if (f_sop) frame_err = 1'b1;
          if (f_eop) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Empty byte-enables are passed through but flagged.
  assign keep_err = wr_en && (f_keep == '0);
  assign err_any  = frame_err || keep_err;

  r2l_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_data ({f_eop, f_data, f_keep}),
    .rd_en   (pop),
    .rd_data (rd_ent),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign tvalid = !fifo_empty;
  assign pop    = tvalid && tready;
  // Head entry is stable until popped, which satisfies AXIS hold rules.
  assign tdata  = tvalid ? rd_ent[KEEP_W +: DATA_W] : '0;
  assign tkeep  = tvalid ? rd_ent[KEEP_W-1:0]       : '0;
  assign tlast  = tvalid && rd_ent[ENT_W-1];

`ifdef ROUTER2AXIS_STATS_EN
  logic [31:0] pkt_q;
  logic [15:0] err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pkt_q <= '0;
      err_q <= '0;
    end else begin
      if (pop && tlast && (pkt_q != '1)) pkt_q <= pkt_q + 32'd1;
      if (err_any && (err_q != '1))      err_q <= err_q + 16'd1;
    end
  end

  assign pkt_cnt = pkt_q;
  assign err_cnt = err_q;
`else
  logic stats_unused;
  assign stats_unused = err_any;
  assign pkt_cnt      = '0;
  assign err_cnt      = '0;
`endif

endmodule
